am_client_arbiter: RTL

Shares one active-message server port among `NUM_CLT` client requesters. On the request side it buffers each client's messages, arbitrates round-robin, stamps the source ID and issues one message per cycle to the server. On the response side it steers each server response to the client named by its `dstid`. It sits between the request engines and a single read/write server, for example the DDR/packet-buffer service.

---
 rtl/am_client_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/am_client_arbiter.sv
// Round-robin share of one active-message server port among NUM_CLT clients; responses steered back by dstid.
// Request latency 2 cycles uncontended (2-entry client FIFO + registered issue); response path is combinational.
// Issue stalls while svr_tx_almost_full; optional counters under AM_CLIENT_ARBITER_STATS_EN.
module am_client_arbiter #(
  parameter int NUM_CLT     = 4,
  parameter int SDARG_BITS  = 32,
  parameter int DATA_BITS   = 512,
  parameter int CLT_ID_BASE = 0,
  localparam int IDX_W = (NUM_CLT > 1) ? $clog2(NUM_CLT) : 1,
  localparam int MSG_W = DATA_BITS + 6*SDARG_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CLT-1:0]       clt_tx,
  input  logic [NUM_CLT*MSG_W-1:0] clt_tx_msg,
  output logic [NUM_CLT-1:0]       clt_tx_full,
  output logic [NUM_CLT-1:0]       clt_tx_almost_full,
  output logic                     svr_tx,
  output logic [MSG_W-1:0]         svr_tx_msg,
  input  logic                     svr_tx_full,
  input  logic                     svr_tx_almost_full,
  input  logic                     svr_rx_empty,
  input  logic [MSG_W-1:0]         svr_rx_msg,
  output logic                     svr_rx_pop,
  output logic [NUM_CLT-1:0]       clt_rx_empty,
  output logic [MSG_W-1:0]         clt_rx_msg,
  input  logic [NUM_CLT-1:0]       clt_rx_pop,
  output logic                     err_overflow
`ifdef AM_CLIENT_ARBITER_STATS_EN
  ,
  output logic [NUM_CLT*32-1:0]    stat_grant,
  output logic [31:0]              stat_drop
`endif
);
  localparam int S = SDARG_BITS;

  logic [MSG_W-1:0] fifo_q [NUM_CLT][2];
  logic [MSG_W-1:0] fifo_d [NUM_CLT][2];
  logic [1:0]       cnt_q  [NUM_CLT];
  logic [1:0]       cnt_d  [NUM_CLT];
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] win, cand;
  logic             found, issue, wr_slot;
  logic [NUM_CLT-1:0] pop, wr_ok;
  logic             svr_tx_q, svr_tx_d;
  logic [MSG_W-1:0] svr_tx_msg_q, svr_tx_msg_d, issue_msg;
  logic             err_q, err_d;
  logic [S-1:0]     rx_d;
  logic             rx_drop;

  // First non-empty client after the last winner.
  always_comb begin
    win   = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CLT; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_CLT);
      if (!found && cnt_q[cand] != 2'd0) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign issue = found & ~svr_tx_almost_full;

  always_comb begin
    issue_msg = fifo_q[win][0];
    issue_msg[6*S-1:5*S] = S'(CLT_ID_BASE) + S'(win);
  end

  // Entry 0 is the head; a pop shifts entry 1 down, so a write lands behind what survives.
  always_comb begin
    fifo_d  = fifo_q;
    cnt_d   = cnt_q;
    pop     = '0;
    wr_ok   = '0;
    wr_slot = 1'b0;
    err_d   = err_q | (svr_tx_q & svr_tx_full);
    for (int i = 0; i < NUM_CLT; i++) begin
      pop[i]   = issue && (win == IDX_W'(i));
      wr_ok[i] = clt_tx[i] && (cnt_q[i] != 2'd2 || pop[i]);
      if (clt_tx[i] && !wr_ok[i]) err_d = 1'b1;
      if (pop[i]) fifo_d[i][0] = fifo_q[i][1];
      wr_slot = ((cnt_q[i] - 2'(pop[i])) != 2'd0);
      if (wr_ok[i]) fifo_d[i][wr_slot] = clt_tx_msg[i*MSG_W +: MSG_W];
      cnt_d[i] = cnt_q[i] - 2'(pop[i]) + 2'(wr_ok[i]);
    end
    svr_tx_d     = issue;
    svr_tx_msg_d = issue ? issue_msg : svr_tx_msg_q;
    rr_ptr_d     = issue ? win : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLT; i++) begin
        fifo_q[i][0] <= '0;
        fifo_q[i][1] <= '0;
        cnt_q[i]     <= 2'd0;
      end
      rr_ptr_q     <= IDX_W'(NUM_CLT-1);
      svr_tx_q     <= 1'b0;
      svr_tx_msg_q <= '0;
      err_q        <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      svr_tx_q     <= svr_tx_d;
      svr_tx_msg_q <= svr_tx_msg_d;
      err_q        <= err_d;
    end
  end

  // Responses for a dstid outside this client range would block forever, so drop them.
  assign rx_d    = svr_rx_msg[5*S-1:4*S] - S'(CLT_ID_BASE);
  assign rx_drop = ~svr_rx_empty & (rx_d >= S'(NUM_CLT));

  always_comb begin
    clt_rx_empty       = '0;
    clt_tx_full        = '0;
    clt_tx_almost_full = '0;
    for (int i = 0; i < NUM_CLT; i++) begin
      clt_rx_empty[i]       = svr_rx_empty | (rx_d != S'(i));
      clt_tx_full[i]        = (cnt_q[i] == 2'd2);
      clt_tx_almost_full[i] = (cnt_q[i] != 2'd0);
    end
  end

  assign svr_rx_pop   = (|(clt_rx_pop & ~clt_rx_empty)) | rx_drop;
  assign clt_rx_msg   = svr_rx_msg;
  assign svr_tx       = svr_tx_q;
  assign svr_tx_msg   = svr_tx_msg_q;
  assign err_overflow = err_q;

`ifdef AM_CLIENT_ARBITER_STATS_EN
  logic [31:0] grant_q [NUM_CLT];
  logic [31:0] grant_d [NUM_CLT];
  logic [31:0] drop_q, drop_d;

  always_comb begin
    grant_d = grant_q;
    for (int i = 0; i < NUM_CLT; i++) grant_d[i] = grant_q[i] + 32'(pop[i]);
    drop_d = drop_q + 32'(rx_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLT; i++) grant_q[i] <= '0;
      drop_q <= '0;
    end else begin
      grant_q <= grant_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    stat_grant = '0;
    for (int i = 0; i < NUM_CLT; i++) stat_grant[i*32 +: 32] = grant_q[i];
  end
  assign stat_drop = drop_q;
`endif

endmodule
